// File: rtl/axil_rd_slave_mem.sv
// AXI4-Lite read-only slave over a reset-initialised memory, with up to MAX_OUT reads in flight.
// Define AXIL_RD_ZERO_IDLE_EN to force rdata/rresp to zero while rvalid is low.
module axil_rd_slave_mem #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 16,
  parameter int READ_LAT  = 2,
  parameter int MAX_OUT   = 4,
  parameter int INIT_MULT = 5
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_areset,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [DATA_W-1:0] s_axi_rdata,
  output logic [1:0]        s_axi_rresp
);

  localparam int OFF = $clog2(DATA_W / 8);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(MAX_OUT + 1);
  localparam int PW  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  logic [ADDR_W-1:0] word_idx;
  logic              in_range;
  logic              ar_hs;
  logic              r_hs;
  logic              fifo_wr;
  logic [DATA_W-1:0] wr_data;
  logic [1:0]        wr_resp;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     fcnt_q, fcnt_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [READ_LAT-1:0] pv_q;
  logic [READ_LAT-1:0] perr_q;
  logic [IW-1:0]     pidx_q  [READ_LAT];
  logic [DATA_W-1:0] mem_q   [DEPTH];
  logic [DATA_W-1:0] fdata_q [MAX_OUT];
  logic [1:0]        fresp_q [MAX_OUT];

  // Range check on the full shifted address so high addresses never alias into the array.
  assign word_idx      = s_axi_araddr >> OFF;
  assign in_range      = word_idx < ADDR_W'(DEPTH);
  assign s_axi_arready = !s_axi_areset && (cnt_q < CW'(MAX_OUT));
  assign ar_hs         = s_axi_arvalid && s_axi_arready;
  assign s_axi_rvalid  = (fcnt_q != '0);
  assign r_hs          = s_axi_rvalid && s_axi_rready;
  assign fifo_wr       = pv_q[READ_LAT-1];
  assign wr_resp       = perr_q[READ_LAT-1] ? 2'b10 : 2'b00;
  assign wr_data       = perr_q[READ_LAT-1] ? '0 : mem_q[pidx_q[READ_LAT-1]];

  always_comb begin
    cnt_d    = cnt_q;
    fcnt_d   = fcnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (ar_hs && !r_hs) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!ar_hs && r_hs) begin
      cnt_d = cnt_q - CW'(1);
    end
    if (fifo_wr && !r_hs) begin
      fcnt_d = fcnt_q + CW'(1);
    end else if (!fifo_wr && r_hs) begin
      fcnt_d = fcnt_q - CW'(1);
    end
    if (fifo_wr) begin
      wr_ptr_d = (wr_ptr_q == PW'(MAX_OUT - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (r_hs) begin
      rd_ptr_d = (rd_ptr_q == PW'(MAX_OUT - 1)) ? '0 : rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      cnt_q    <= '0;
      fcnt_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      pv_q     <= '0;
      perr_q   <= '0;
      for (int i = 0; i < READ_LAT; i++) pidx_q[i] <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= DATA_W'(i * INIT_MULT);
      for (int i = 0; i < MAX_OUT; i++) begin
        fdata_q[i] <= '0;
        fresp_q[i] <= '0;
      end
    end else begin
      cnt_q     <= cnt_d;
      fcnt_q    <= fcnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pv_q[0]   <= ar_hs;
      perr_q[0] <= !in_range;
      pidx_q[0] <= word_idx[IW-1:0];
      for (int i = 1; i < READ_LAT; i++) begin
        pv_q[i]   <= pv_q[i-1];
        perr_q[i] <= perr_q[i-1];
        pidx_q[i] <= pidx_q[i-1];
      end
      // Credit bound guarantees a free slot whenever the pipeline delivers.
      if (fifo_wr) begin
        fdata_q[wr_ptr_q] <= wr_data;
        fresp_q[wr_ptr_q] <= wr_resp;
      end
    end
  end

`ifdef AXIL_RD_ZERO_IDLE_EN
  assign s_axi_rdata = s_axi_rvalid ? fdata_q[rd_ptr_q] : '0;
  assign s_axi_rresp = s_axi_rvalid ? fresp_q[rd_ptr_q] : 2'b00;
`else
  assign s_axi_rdata = fdata_q[rd_ptr_q];
  assign s_axi_rresp = fresp_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_axil_rd_slave_mem.sv
// Self-checking bench for axil_rd_slave_mem: directed scenarios plus random traffic
// against a transaction-level model (ordered queue of expected beats with ready times).
module tb_axil_rd_slave_mem;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int DEPTH     = 16;
  localparam int READ_LAT  = 2;
  localparam int MAX_OUT   = 4;
  localparam int INIT_MULT = 5;

  logic              clk;
  logic              areset;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    int                ready_at;
  } beat_t;

  beat_t             exp_q[$];
  beat_t             nb;
  logic [DATA_W-1:0] pop_data[$];
  logic [1:0]        pop_resp[$];
  int                n_vec = 0;
  int                n_err = 0;
  int                cyc = 0;
  logic              prev_idle = 1'b0;
  logic [DATA_W-1:0] prev_rdata = '0;
  logic [1:0]        prev_rresp = '0;
  logic              exp_rv;

  axil_rd_slave_mem #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .READ_LAT(READ_LAT), .MAX_OUT(MAX_OUT), .INIT_MULT(INIT_MULT)
  ) dut (
    .s_axi_aclk   (clk),
    .s_axi_areset (areset),
    .s_axi_arvalid(arvalid),
    .s_axi_arready(arready),
    .s_axi_araddr (araddr),
    .s_axi_rvalid (rvalid),
    .s_axi_rready (rready),
    .s_axi_rdata  (rdata),
    .s_axi_rresp  (rresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic beat_t model_read(input logic [ADDR_W-1:0] a, input int ready_at);
    beat_t b;
    longint unsigned idx;
    idx = longint'(a) / (DATA_W / 8);
    b.ready_at = ready_at;
    if (idx < DEPTH) begin
      b.data = DATA_W'(idx * INIT_MULT);
      b.resp = 2'b00;
    end else begin
      b.data = '0;
      b.resp = 2'b10;
    end
    return b;
  endfunction

  // Monitor: samples mid-cycle and predicts what the next rising edge will do.
  always @(negedge clk) begin
    if (areset) begin
      chk("arready_in_reset", {63'b0, arready}, 64'd0);
      exp_q.delete();
      prev_idle = 1'b0;
    end else begin
      exp_rv = (exp_q.size() > 0) && (exp_q[0].ready_at <= cyc);
      chk("rvalid", {63'b0, rvalid}, {63'b0, exp_rv});
      chk("arready", {63'b0, arready}, {63'b0, exp_q.size() < MAX_OUT});
      if (rvalid && exp_rv) begin
        chk("rdata", 64'(rdata), 64'(exp_q[0].data));
        chk("rresp", 64'(rresp), 64'(exp_q[0].resp));
      end
`ifdef AXIL_RD_ZERO_IDLE_EN
      if (!rvalid) begin
        chk("idle_rdata_zero", 64'(rdata), 64'd0);
        chk("idle_rresp_zero", 64'(rresp), 64'd0);
      end
`else
      if (!rvalid && prev_idle) begin
        chk("idle_rdata_stable", 64'(rdata), 64'(prev_rdata));
        chk("idle_rresp_stable", 64'(rresp), 64'(prev_rresp));
      end
`endif
      if (rvalid && rready && exp_q.size() > 0) begin
        pop_data.push_back(rdata);
        pop_resp.push_back(rresp);
        void'(exp_q.pop_front());
      end
      if (arvalid && arready) begin
        nb = model_read(araddr, cyc + 1 + READ_LAT);
        exp_q.push_back(nb);
      end
      prev_idle  = !rvalid;
      prev_rdata = rdata;
      prev_rresp = rresp;
    end
  end

  task automatic send_ar(input logic [ADDR_W-1:0] a);
    int n = 0;
    arvalid = 1'b1;
    araddr  = a;
    @(negedge clk);
    while (!arready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("ar_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    rready = 1'b1;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("drain_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic chk_log(input string tag, input int idx, input logic [DATA_W-1:0] d,
                         input logic [1:0] r);
    if (idx < pop_data.size()) begin
      chk({tag, "_data"}, 64'(pop_data[idx]), 64'(d));
      chk({tag, "_resp"}, 64'(pop_resp[idx]), 64'(r));
    end else begin
      chk({tag, "_missing"}, 64'(pop_data.size()), 64'(idx + 1));
    end
  endtask

  initial begin
    int n;
    areset  = 1'b1;
    arvalid = 1'b0;
    araddr  = '0;
    rready  = 1'b0;
    repeat (3) @(posedge clk);
    #1 areset = 1'b0;

    // Single read at 0x1C
    @(negedge clk);
    chk("arready_post_rst", {63'b0, arready}, 64'd1);
    chk("rvalid_post_rst", {63'b0, rvalid}, 64'd0);
    chk("rdata_post_rst", 64'(rdata), 64'd0);
    chk("rresp_post_rst", 64'(rresp), 64'd0);
    @(posedge clk); #1;
    rready = 1'b1;
    pop_data.delete(); pop_resp.delete();
    send_ar(32'h1C);
    @(negedge clk); chk("lat_c0", {63'b0, rvalid}, 64'd0);
    @(negedge clk); chk("lat_c1", {63'b0, rvalid}, 64'd0);
    @(negedge clk); chk("lat_c2", {63'b0, rvalid}, 64'd1);
    chk("rd_1c", 64'(rdata), 64'd35);
    @(negedge clk); chk("rvalid_drop", {63'b0, rvalid}, 64'd0);
    chk_log("single", 0, 35, 2'b00);
    @(posedge clk); #1;

    // Back-pressure: four reads fill credits, fifth stalls
    rready = 1'b0;
    pop_data.delete(); pop_resp.delete();
    for (int i = 0; i < 4; i++) send_ar(ADDR_W'(i * 4));
    arvalid = 1'b1;
    araddr  = 32'h10;
    repeat (3) begin
      @(negedge clk);
      chk("stall_arready", {63'b0, arready}, 64'd0);
    end
    @(posedge clk); #1;
    rready = 1'b1;
    @(negedge clk); chk("arready_before_r", {63'b0, arready}, 64'd0);
    @(negedge clk); chk("arready_after_r", {63'b0, arready}, 64'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    drain();
    for (int i = 0; i < 5; i++) chk_log("bp", i, DATA_W'(i * 5), 2'b00);

    // Out-of-range then in-range
    pop_data.delete(); pop_resp.delete();
    send_ar(32'h40);
    send_ar(32'hFFFF_FFFC);
    send_ar(32'h3C);
    drain();
    chk_log("oor40", 0, 0, 2'b10);
    chk_log("oorfc", 1, 0, 2'b10);
    chk_log("last", 2, 75, 2'b00);

    // Eight back-to-back with rready held high
    pop_data.delete(); pop_resp.delete();
    for (int i = 0; i < 8; i++) send_ar(ADDR_W'(i * 4));
    drain();
    for (int i = 0; i < 8; i++) chk_log("b2b", i, DATA_W'(i * 5), 2'b00);

    // Reset with three beats outstanding
    rready = 1'b0;
    pop_data.delete(); pop_resp.delete();
    for (int i = 0; i < 3; i++) send_ar(ADDR_W'(i * 4 + 4));
    areset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); chk("rvalid_after_rst_edge", {63'b0, rvalid}, 64'd0);
    @(posedge clk); #1;
    areset = 1'b0;
    rready = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("no_stale", {63'b0, rvalid}, 64'd0);
    end
    @(posedge clk); #1;
    rready = 1'b0;
    for (int i = 0; i < 4; i++) send_ar(ADDR_W'(i * 4));
    arvalid = 1'b1;
    araddr  = 32'h20;
    @(negedge clk); chk("stall_after_rst", {63'b0, arready}, 64'd0);
    @(posedge clk); #1;
    arvalid = 1'b0;
    drain();
    chk("no_pop_before_new", 64'(pop_data.size()), 64'd4);

    // Random traffic, including dropped arvalid and occasional reset
    for (int c = 0; c < 3000; c++) begin
      arvalid = ($urandom_range(0, 3) != 0);
      n = $urandom_range(0, 9);
      if (n == 0) araddr = $urandom;
      else araddr = ADDR_W'(($urandom_range(0, 19) << 2) | $urandom_range(0, 3));
      rready = ($urandom_range(0, 3) != 0);
      areset = ($urandom_range(0, 299) == 0);
      @(posedge clk); #1;
    end
    areset  = 1'b0;
    arvalid = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axil_rd_slave_mem.md
# axil_rd_slave_mem

Parametrised AXI4-Lite read-only slave that serves a reset-initialised memory, the next generation of the single-outstanding point-to-point read slave. Generalised in data width, memory depth and read latency; supports up to MAX_OUT outstanding reads with in-order responses and full throughput. Out-of-range accesses return SLVERR. Sits behind any AXI-Lite read master on the single system clock.

## Interface
- DATA_W, 32: data width in bits; 32 or 64.
- ADDR_W, 32: AR address width.
- DEPTH, 16: memory words; power of 2, ≥2.
- READ_LAT, 2: cycles from AR handshake to rvalid; 1..4.
- MAX_OUT, 4: maximum outstanding reads (accepted, not yet R-handshaked); 1..8.
- INIT_MULT, 5: reset contents are mem[i] = i*INIT_MULT, truncated to DATA_W.

- s_axi_aclk  in  1  clock; all logic on the rising edge.
- s_axi_areset  in  1  synchronous, active-high reset.
- s_axi_arvalid  in  1  read address valid.
- s_axi_arready  out  1  read address ready.
- s_axi_araddr  in  ADDR_W  byte address.
- s_axi_rvalid  out  1  read data valid.
- s_axi_rready  in  1  read data ready.
- s_axi_rdata  out  DATA_W  read data.
- s_axi_rresp  out  2  00 OKAY, 10 SLVERR.

## Operation
- Word index = araddr >> log2(DATA_W/8). Low byte-offset bits are ignored.
- In range (index < DEPTH): rdata = mem[index], rresp = 00. Out of range: rdata = 0, rresp = 10. The range check uses the full araddr, with no aliasing.
- Credit counter `cnt` (0..MAX_OUT) is registered:
  - +1 on an AR handshake (arvalid & arready).
  - −1 on an R handshake (rvalid & rready).
  - Unchanged when both occur in the same cycle.
- arready = !s_axi_areset && (cnt < MAX_OUT). It does not depend combinationally on arvalid.
- Accepted requests enter a READ_LAT-stage valid/index pipeline. The memory read and response code are produced in that pipeline.
- Pipeline exit writes an R FIFO of depth MAX_OUT. Because of the credit bound, the FIFO cannot overflow.
- rvalid = FIFO not empty. The head beat is held stable while rvalid & !rready.
- Responses return strictly in AR order.
- No write channel. Memory contents change only at reset.
- Reset (any cycle, including mid-operation) does all of the following:
  - clears cnt, the pipeline and the FIFO;
  - reloads mem with i*INIT_MULT;
  - produces no stale beat after reset is released.
- Reset values: arready 0 while reset is high, then 1 in the first cycle after release. rvalid 0, rdata 0, rresp 00.

## Timing
- AR handshake at edge N: rvalid is high after edge N+READ_LAT if the FIFO was empty. Otherwise the beat queues behind earlier beats.
- Throughput is one read per cycle with arvalid and rready held high and MAX_OUT ≥ READ_LAT+1. With MAX_OUT ≤ READ_LAT, throughput is MAX_OUT per READ_LAT+1 cycles.
- cnt = MAX_OUT forces arready low. An R handshake at edge M makes arready high after edge M.
- Simultaneous AR and R handshake at cnt = MAX_OUT is impossible, because arready is already low.
- arvalid can drop without a handshake (protocol violation): nothing is captured and there is no state change.

## Configuration
- AXIL_RD_ZERO_IDLE_EN defined: s_axi_rdata and s_axi_rresp are forced to 0 whenever rvalid is low.
- Not defined: they present the FIFO head register, whose value is undefined-but-stable when empty. This saves output muxing.
- Handshake timing is identical in both builds.

## Test plan
Defaults: DATA_W=32, DEPTH=16, READ_LAT=2, MAX_OUT=4, INIT_MULT=5.
- Release reset, single read at araddr 0x1C: arready is 1 in the first post-reset cycle. rvalid rises 2 cycles after the handshake with rdata 35, rresp 00, and drops after the rready handshake.
- rready=0, issue reads at 0x00, 0x04, 0x08, 0x0C, 0x10: arready drops after the 4th handshake and the 5th read stalls. Raise rready: beats 0, 5, 10, 15 return in order. arready rises the cycle after the first R handshake, and the 5th beat returns 20.
- Read at 0x40 (index 16) and 0xFFFF_FFFC: both return rresp 10, rdata 0. A following read at 0x3C returns 75 with OKAY.
- rready held 1, 8 back-to-back reads at 0x00..0x1C: rvalid is continuous for 8 cycles starting 2 cycles after the first handshake, with data 0, 5, …, 35.
- Assert reset with 3 beats outstanding (1 in FIFO, 2 in the pipeline): rvalid is 0 the cycle after the reset edge. No beat appears after release, and cnt restarts at 0 (4 new reads accepted before stall).
- Run the rready=0 scenario in both builds: with AXIL_RD_ZERO_IDLE_EN, rdata/rresp are 0 whenever rvalid=0. Without it, rdata/rresp are stable and handshake timing is identical.
